wb_mux_tmo: RTL

Registered-decode Wishbone B4 classic 1-to-N slave multiplexer for the SoC IO bus. It is the parametrised successor to the fixed eight-slave IO interconnect. It generalises slave count, data width and address map. It adds the following behaviour the current mux lacks:
- an error response for unmapped addresses;
- a per-transfer bus-timeout watchdog that errors out hung slaves;
- a latched error-status register with an interrupt pulse for firmware diagnosis.

---
 rtl/wb_mux_pkg.sv | 26 ++
 rtl/wb_mux_tmo_cnt.sv | 33 +++
 rtl/wb_mux_tmo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_mux_pkg.sv
// wb_mux_pkg: shared types and constants for the wb_mux_tmo Wishbone slave multiplexer.
package wb_mux_pkg;

  // Transfer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_e;

  // Latched error-status codes
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Default watchdog limit in bus cycles
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  // True when an address falls inside a base/mask window
  function automatic logic addr_hit(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/wb_mux_tmo_cnt.sv
// wb_mux_tmo_cnt: saturating bus-timeout watchdog counter.
// expire is high while the count sits at LIMIT-1.
module wb_mux_tmo_cnt
  import wb_mux_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles, hold at the limit, clear on request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/wb_mux_tmo.sv
// wb_mux_tmo: registered-decode Wishbone B4 classic 1-to-N slave multiplexer
// with unmapped-address error, bus-timeout watchdog and latched error status.
// Define WB_MUX_TMO_EN to build the timeout counter and timeout error path.
module wb_mux_tmo
  import wb_mux_pkg::*;
#(
  parameter int unsigned                NUM_SLAVES     = 8,
  parameter int unsigned                DW             = 32,
  parameter logic [NUM_SLAVES*32-1:0]   MATCH_ADDR     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]   MATCH_MASK     = {NUM_SLAVES{32'h0}},
  parameter int unsigned                TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  // master request
  input  logic [31:0]                wbm_adr_i,
  input  logic [DW-1:0]              wbm_dat_i,
  input  logic [DW/8-1:0]            wbm_sel_i,
  input  logic                       wbm_we_i,
  input  logic                       wbm_cyc_i,
  input  logic                       wbm_stb_i,
  input  logic [2:0]                 wbm_cti_i,
  input  logic [1:0]                 wbm_bte_i,
  // master response
  output logic [DW-1:0]              wbm_dat_o,
  output logic                       wbm_ack_o,
  output logic                       wbm_err_o,
  output logic                       wbm_rty_o,
  // slave requests
  output logic [NUM_SLAVES*32-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]   wbs_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]      wbs_we_o,
  output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]      wbs_stb_o,
  output logic [NUM_SLAVES*3-1:0]    wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]    wbs_bte_o,
  // slave responses
  input  logic [NUM_SLAVES*DW-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]      wbs_err_i,
  input  logic [NUM_SLAVES-1:0]      wbs_rty_i,
  // error status
  output logic [1:0]                 err_code_o,
  output logic [31:0]                err_addr_o,
  output logic                       err_irq_o,
  input  logic                       err_clr_i
);

  localparam int unsigned SELW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_e            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              hit;
  logic [SELW-1:0]   hit_idx;
  logic              sel_ack, sel_err, sel_rty;
  logic [DW-1:0]     sel_dat;
  logic              resp;
  logic              tmo_expire;
  logic              err_set;
  logic [1:0]        err_code_set;

  // Request fields go to every slave unchanged
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

  // Address decode: lowest-index matching slave wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && addr_hit(wbm_adr_i, MATCH_ADDR[i*32 +: 32], MATCH_MASK[i*32 +: 32])) begin
        hit     = 1'b1;
        hit_idx = SELW'(i);
      end
    end
  end

  // Response mux from the registered slave index
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rty = 1'b0;
    sel_dat = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (SELW'(i) == sel_q) begin
        sel_ack = wbs_ack_i[i];
        sel_err = wbs_err_i[i];
        sel_rty = wbs_rty_i[i];
        sel_dat = wbs_dat_i[i*DW +: DW];
      end
    end
  end

  assign resp = (sel_ack | sel_err | sel_rty) & wbm_stb_i;

`ifdef WB_MUX_TMO_EN
  wb_mux_tmo_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_cnt (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (state_q != ACTIVE),
    .en     ((state_q == ACTIVE) && !resp),
    .expire (tmo_expire)
  );
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_expire = 1'b0;
`endif

  // FSM state and selected-slave registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state, slave gating and master response
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    wbs_cyc_o    = '0;
    wbs_stb_o    = '0;
    wbm_ack_o    = 1'b0;
    wbm_err_o    = 1'b0;
    wbm_rty_o    = 1'b0;
    wbm_dat_o    = '0;
    err_set      = 1'b0;
    err_code_set = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit) begin
            state_d = ACTIVE;
            sel_d   = hit_idx;
          end else begin
            state_d = ERR;
          end
        end
      end
      ACTIVE: begin
        wbm_dat_o = sel_dat;
        // watchdog expiry overrides the slave: strobe is withdrawn and its response ignored
        if (tmo_expire) begin
          wbm_err_o    = 1'b1;
          err_set      = 1'b1;
          err_code_set = ERR_TIMEOUT;
          state_d      = IDLE;
        end else begin
          for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (SELW'(i) == sel_q) begin
              wbs_cyc_o[i] = wbm_cyc_i;
              wbs_stb_o[i] = wbm_stb_i;
            end
          end
          wbm_ack_o = sel_ack & wbm_stb_i;
          wbm_err_o = sel_err & wbm_stb_i;
          wbm_rty_o = sel_rty & wbm_stb_i;
          if (resp || !wbm_cyc_i) begin
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        wbm_err_o    = 1'b1;
        err_set      = 1'b1;
        err_code_set = ERR_UNMAPPED;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Error status: a new error beats a simultaneous clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_code_o <= ERR_NONE;
      err_addr_o <= '0;
      err_irq_o  <= 1'b0;
    end else begin
      err_irq_o <= err_set;
      if (err_set) begin
        err_code_o <= err_code_set;
        err_addr_o <= wbm_adr_i;
      end else if (err_clr_i) begin
        err_code_o <= ERR_NONE;
        err_addr_o <= '0;
      end
    end
  end

endmodule
